// File: rtl/d2d_flit_tx.sv
// d2d_flit_tx: die-to-die flit transmit stage.
// Buffers 101-bit router flits in a small FIFO and serialises each flit onto
// a LANE_W-bit lane as BEATS beats, LSB first, gated by receiver credits.
// Optional feature macro: D2D_TX_PARITY_EN adds LANE_PAR (XOR of LANE_DATA).
module d2d_flit_tx #(
    parameter int LANE_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDITS    = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [100:0]                    FLIT_IN,
    input  logic                            FLIT_IN_VALID,
    output logic                            FLIT_IN_READY,
    output logic [LANE_W-1:0]               LANE_DATA,
    output logic                            LANE_VALID,
    output logic                            LANE_SOF,
`ifdef D2D_TX_PARITY_EN
    output logic                            LANE_PAR,
`endif
    input  logic                            CREDIT_RET,
    output logic [$clog2(CREDITS+1)-1:0]    CREDIT_CNT,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] FIFO_CNT,
    output logic                            CREDIT_ERR
);

    localparam int FLIT_W = 101;
    localparam int BEATS  = (FLIT_W + LANE_W - 1) / LANE_W;
    localparam int PW     = BEATS * LANE_W;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = $clog2(CREDITS + 1);
    localparam int FW     = $clog2(FIFO_DEPTH + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [FW-1:0] FIFO_FULL = FW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

`ifdef D2D_TX_PARITY_EN
    function automatic logic parity_f(input logic [LANE_W-1:0] d);
        return ^d;
    endfunction
`endif

    // Registered state
    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [FW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic              ready_q, ready_d;
    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [PW-1:0]     shift_q, shift_d;
    logic [LANE_W-1:0] lane_data_q, lane_data_d;
    logic              lane_valid_q, lane_valid_d;
    logic              lane_sof_q, lane_sof_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic              err_q, err_d;
`ifdef D2D_TX_PARITY_EN
    logic              lane_par_q;
`endif

    // Combinational helpers
    logic              wr_s;
    logic              launch_s;
    logic              can_launch_s;
    logic [PW-1:0]     head_ext_s;

    assign wr_s         = FLIT_IN_VALID & ready_q;
    assign can_launch_s = (fifo_cnt_q != '0) && (credit_q != '0);

    // Zero-extend the FIFO head to a whole number of beats
    always_comb begin
        head_ext_s             = '0;
        head_ext_s[FLIT_W-1:0] = mem_q[rptr_q];
    end

    // FSM next state and next lane beat; a launch loads beat 0 directly
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        shift_d      = shift_q;
        lane_data_d  = '0;
        lane_valid_d = 1'b0;
        lane_sof_d   = 1'b0;
        launch_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_launch_s) begin
                    launch_s     = 1'b1;
                    state_d      = SEND;
                    beat_d       = '0;
                    lane_valid_d = 1'b1;
                    lane_sof_d   = 1'b1;
                    lane_data_d  = head_ext_s[LANE_W-1:0];
                    shift_d      = head_ext_s >> LANE_W;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (beat_q == LAST_BEAT) begin
                    if (can_launch_s) begin
                        launch_s     = 1'b1;
                        state_d      = SEND;
                        beat_d       = '0;
                        lane_valid_d = 1'b1;
                        lane_sof_d   = 1'b1;
                        lane_data_d  = head_ext_s[LANE_W-1:0];
                        shift_d      = head_ext_s >> LANE_W;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lane_valid_d = 1'b1;
                    lane_data_d  = shift_q[LANE_W-1:0];
                    shift_d      = shift_q >> LANE_W;
                    beat_d       = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO occupancy and READY; READY only reflects registered occupancy
    always_comb begin
        case ({wr_s, launch_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        ready_d = (fifo_cnt_d != FIFO_FULL);
    end

    // Credit counter with saturation and sticky overflow flag
    always_comb begin
        err_d = err_q;
        case ({launch_s, CREDIT_RET})
            2'b10: credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CRED_MAX) begin
                    credit_d = credit_q;
                    err_d    = 1'b1;
                end else begin
                    credit_d = credit_q + 1'b1;
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    // FIFO storage and pointers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            if (wr_s) begin
                mem_q[wptr_q] <= FLIT_IN;
                wptr_q        <= (wptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (launch_s) begin
                rptr_q <= (rptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            end
            fifo_cnt_q <= fifo_cnt_d;
            ready_q    <= ready_d;
        end
    end

    // FSM state, serialiser and registered lane outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            shift_q      <= '0;
            lane_data_q  <= '0;
            lane_valid_q <= 1'b0;
            lane_sof_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            shift_q      <= shift_d;
            lane_data_q  <= lane_data_d;
            lane_valid_q <= lane_valid_d;
            lane_sof_q   <= lane_sof_d;
        end
    end

    // Credit state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            credit_q <= CRED_MAX;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            err_q    <= err_d;
        end
    end

`ifdef D2D_TX_PARITY_EN
    // Lane parity registered alongside the data (data is 0 when idle)
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane_par_q <= 1'b0;
        end else begin
            lane_par_q <= parity_f(lane_data_d);
        end
    end

    assign LANE_PAR = lane_par_q;
`endif

    assign FLIT_IN_READY = ready_q;
    assign LANE_DATA     = lane_data_q;
    assign LANE_VALID    = lane_valid_q;
    assign LANE_SOF      = lane_sof_q;
    assign CREDIT_CNT    = credit_q;
    assign FIFO_CNT      = fifo_cnt_q;
    assign CREDIT_ERR    = err_q;

endmodule

// File: tb/tb_d2d_flit_tx.sv
// Directed testbench for d2d_flit_tx (default parameters: LANE_W=16, 7 beats).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_d2d_flit_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic [100:0] flit_in;
    logic         flit_in_valid;
    logic         flit_in_ready;
    logic [15:0]  lane_data;
    logic         lane_valid;
    logic         lane_sof;
    logic         credit_ret;
    logic [3:0]   credit_cnt;
    logic [2:0]   fifo_cnt;
    logic         credit_err;
`ifdef D2D_TX_PARITY_EN
    logic         lane_par;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] obs_beats [7];
    logic [15:0] s1_beats  [7];
    logic [100:0] flits    [4];
    int acc;
    int sofs;

    always #5 clk = ~clk;

    d2d_flit_tx dut (
        .CLK           (clk),
        .RST           (rst),
        .FLIT_IN       (flit_in),
        .FLIT_IN_VALID (flit_in_valid),
        .FLIT_IN_READY (flit_in_ready),
        .LANE_DATA     (lane_data),
        .LANE_VALID    (lane_valid),
        .LANE_SOF      (lane_sof),
`ifdef D2D_TX_PARITY_EN
        .LANE_PAR      (lane_par),
`endif
        .CREDIT_RET    (credit_ret),
        .CREDIT_CNT    (credit_cnt),
        .FIFO_CNT      (fifo_cnt),
        .CREDIT_ERR    (credit_err)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold reset for two cycles, check reset values, release on a falling edge
    task automatic do_reset();
        rst           = 1'b1;
        flit_in       = '0;
        flit_in_valid = 1'b0;
        credit_ret    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready", flit_in_ready, 1'b0);
        check_eq("rst_valid", lane_valid, 1'b0);
        check_eq("rst_data", lane_data, 16'h0000);
        check_eq("rst_sof", lane_sof, 1'b0);
        check_eq("rst_credit", credit_cnt, 4'd8);
        check_eq("rst_fifo", fifo_cnt, 3'd0);
        check_eq("rst_err", credit_err, 1'b0);
`ifdef D2D_TX_PARITY_EN
        check_eq("rst_par", lane_par, 1'b0);
`endif
        rst = 1'b0;
    endtask

    // Send one flit into an idle block and check its full beat sequence
    task automatic run_single(input logic [100:0] f, input logic [3:0] cred_exp);
        logic [111:0] e;
        e = {11'b0, f};
        @(negedge clk);
        check_eq("single_ready", flit_in_ready, 1'b1);
        flit_in       = f;
        flit_in_valid = 1'b1;
        @(negedge clk);
        flit_in_valid = 1'b0;
        check_eq("single_c1_valid", lane_valid, 1'b0);
        check_eq("single_c1_fifo", fifo_cnt, 3'd1);
`ifdef D2D_TX_PARITY_EN
        check_eq("single_c1_par", lane_par, 1'b0);
`endif
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            obs_beats[b] = lane_data;
            check_eq("single_valid", lane_valid, 1'b1);
            check_eq("single_sof", lane_sof, (b == 0));
            check_eq("single_data", lane_data, e[b*16 +: 16]);
`ifdef D2D_TX_PARITY_EN
            check_eq("single_par", lane_par, ^e[b*16 +: 16]);
`endif
        end
        @(negedge clk);
        check_eq("single_end_valid", lane_valid, 1'b0);
        check_eq("single_end_credit", credit_cnt, cred_exp);
`ifdef D2D_TX_PARITY_EN
        check_eq("single_end_par", lane_par, 1'b0);
`endif
    endtask

    initial begin
        s1_beats = '{16'h6789, 16'h2345, 16'hEF01, 16'hABCD, 16'h6789, 16'h2345, 16'h0001};
        flits[0] = 101'h0_1111_2222_3333_4444_5555_6666;
        flits[1] = 101'h1_FEDC_BA98_7654_3210_0F0F_F0F0;
        flits[2] = 101'h1_0000_0000_0000_0000_0000_0001;
        flits[3] = 101'h0_A5A5_5A5A_C3C3_3C3C_9999_7777;

        // 1: single flit, latency and beat order
        do_reset();
        run_single(101'h1_2345_6789_ABCD_EF01_2345_6789, 4'd7);
        for (int b = 0; b < 7; b++) begin
            check_eq("s1_beat_table", obs_beats[b], s1_beats[b]);
        end

        // 2: four back-to-back flits, 28 contiguous beats
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c <= 29) begin
                check_eq("s2_ready", flit_in_ready, 1'b1);
            end
            if (c >= 2 && c <= 29) begin
                logic [111:0] e;
                e = {11'b0, flits[(c-2)/7]};
                check_eq("s2_valid", lane_valid, 1'b1);
                check_eq("s2_sof", lane_sof, ((c - 2) % 7) == 0);
                check_eq("s2_data", lane_data, e[((c-2)%7)*16 +: 16]);
            end
            if (c == 30) begin
                check_eq("s2_end_valid", lane_valid, 1'b0);
                check_eq("s2_end_credit", credit_cnt, 4'd4);
            end
            flit_in_valid = (c < 4);
            flit_in       = (c < 4) ? flits[c] : '0;
        end
        flit_in_valid = 1'b0;

        // 3: credit starvation, then one returned credit
        do_reset();
        acc  = 0;
        sofs = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (lane_sof) sofs++;
            flit_in       = 101'(c + 1);
            flit_in_valid = 1'b1;
            if (flit_in_ready) acc++;
        end
        @(negedge clk);
        flit_in_valid = 1'b0;
        check_eq("s3_flits_sent", sofs, 8);
        check_eq("s3_accepted", acc, 12);
        check_eq("s3_fifo_full", fifo_cnt, 3'd4);
        check_eq("s3_ready_low", flit_in_ready, 1'b0);
        check_eq("s3_lane_idle", lane_valid, 1'b0);
        check_eq("s3_credit_zero", credit_cnt, 4'd0);
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        check_eq("s3_ret_c1_valid", lane_valid, 1'b0);
        check_eq("s3_ret_c1_credit", credit_cnt, 4'd1);
        @(negedge clk);
        check_eq("s3_ret_c2_valid", lane_valid, 1'b1);
        check_eq("s3_ret_c2_sof", lane_sof, 1'b1);
        check_eq("s3_ret_c2_credit", credit_cnt, 4'd0);
        sofs = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (lane_sof) sofs++;
        end
        check_eq("s3_one_more_flit", sofs, 1);
        check_eq("s3_end_fifo", fifo_cnt, 3'd3);
        check_eq("s3_end_valid", lane_valid, 1'b0);

        // 4a: credit return coincident with a launch at CREDIT_CNT=3
        do_reset();
        acc = 0;
        for (int c = 0; c <= 38; c++) begin
            @(negedge clk);
            if (c == 36) begin
                check_eq("s4_pre_credit", credit_cnt, 4'd3);
                credit_ret = 1'b1;
            end else begin
                credit_ret = 1'b0;
            end
            if (c == 37) begin
                check_eq("s4_coinc_credit", credit_cnt, 4'd3);
                check_eq("s4_coinc_sof", lane_sof, 1'b1);
            end
            if (c == 38) begin
                check_eq("s4_post_credit", credit_cnt, 4'd3);
            end
            flit_in       = 101'(c + 100);
            flit_in_valid = (acc < 6);
            if (flit_in_valid && flit_in_ready) acc++;
        end
        flit_in_valid = 1'b0;
        credit_ret    = 1'b0;

        // 4b: credit overflow while idle at CREDIT_CNT=8
        do_reset();
        @(negedge clk);
        check_eq("s4_err_before", credit_err, 1'b0);
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        check_eq("s4_ovf_credit", credit_cnt, 4'd8);
        check_eq("s4_ovf_err", credit_err, 1'b1);
        repeat (5) @(negedge clk);
        check_eq("s4_err_sticky", credit_err, 1'b1);

        // 5: reset during beat 3 (do_reset also checks CREDIT_ERR clears)
        do_reset();
        @(negedge clk);
        flit_in       = 101'h1_2345_6789_ABCD_EF01_2345_6789;
        flit_in_valid = 1'b1;
        @(negedge clk);
        flit_in       = 101'h0_0BAD_CAFE_0000_1111_2222_3333;
        @(negedge clk);
        flit_in_valid = 1'b0;
        check_eq("s5_beat0_sof", lane_sof, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_eq("s5_beat3_valid", lane_valid, 1'b1);
        check_eq("s5_beat3_data", lane_data, 16'hABCD);
        check_eq("s5_beat3_fifo", fifo_cnt, 3'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("s5_async_valid", lane_valid, 1'b0);
        check_eq("s5_async_fifo", fifo_cnt, 3'd0);
        check_eq("s5_async_credit", credit_cnt, 4'd8);
        check_eq("s5_async_ready", flit_in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_single(101'h0_0000_FFFF_0000_8000_0001_00FF, 4'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
